// File: rtl/cdc_4phase_rsp.sv
// cdc_4phase_rsp: destination-side responder for a 4-phase request/response async channel.
// Latency: req_valid_o rises SYNC_STAGES+1 edges after async_req_i rises; ack rises one edge after rsp handshake.
// Backpressure: holds req_valid_o/req_data_o until req_ready_i, then waits on rsp_valid_i (optionally bounded by a timeout).
//
// Ports:
//   clk_i, rst_ni                 local clock, synchronous active-low reset
//   async_req_i, async_req_data_i remote request and its word (stable while request is high)
//   async_ack_o, async_rsp_data_o flopped acknowledge and response word returned to the initiator
//   req_valid_o/req_ready_i/req_data_o   local request handshake
//   rsp_valid_i/rsp_ready_o/rsp_data_i   local response handshake
//   timeout_o                     one-cycle timeout pulse (only with CDC_4PHASE_RSP_TIMEOUT_EN)
//   busy_o                        high whenever the FSM is not idle
// Optional feature macro: CDC_4PHASE_RSP_TIMEOUT_EN (response timeout returning ERR_RSP).
module cdc_4phase_rsp #(
  parameter type         REQ_T          = logic [31:0],
  parameter type         RSP_T          = logic [31:0],
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter RSP_T        ERR_RSP        = RSP_T'('1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_req_i,
  input  REQ_T async_req_data_i,
  output logic async_ack_o,
  output RSP_T async_rsp_data_o,
  output logic req_valid_o,
  input  logic req_ready_i,
  output REQ_T req_data_o,
  input  logic rsp_valid_i,
  output logic rsp_ready_o,
  input  RSP_T rsp_data_i,
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
  output logic timeout_o,
`endif
  output logic busy_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ_VALID = 2'd1;
  localparam logic [1:0] WAIT_RSP  = 2'd2;
  localparam logic [1:0] ACK_HIGH  = 2'd3;

  // Elaboration-time parameter sanity.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("cdc_4phase_rsp: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("cdc_4phase_rsp: TIMEOUT_CYCLES must be >= 1");
  end
  if ($bits(ERR_RSP) != $bits(RSP_T)) begin : g_chk_err
    $error("cdc_4phase_rsp: ERR_RSP width mismatch");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_synced;
  logic [1:0]             state;
  REQ_T                   req_q;
  RSP_T                   rsp_q;
  logic                   ack_q;

  assign req_synced = sync_q[SYNC_STAGES-1];

`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             tmo_hit;
  logic             timeout_q;

  // cnt holds the number of cycles already spent in REQ_VALID/WAIT_RSP, so
  // the timeout fires on the TIMEOUT_CYCLES-th edge after entering REQ_VALID.
  assign tmo_hit   = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      state     <= IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      ack_q     <= 1'b0;
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
      cnt       <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_req_i};
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // The request word is only sampled here; it is stable because the
          // initiator holds it for as long as async_req_i is high.
          if (req_synced) begin
            req_q <= async_req_data_i;
            state <= REQ_VALID;
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        REQ_VALID: begin
          if (req_ready_i) begin
            state <= WAIT_RSP;
          end
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_q     <= ERR_RSP;
            ack_q     <= 1'b1;
            state     <= ACK_HIGH;
            timeout_q <= 1'b1;
          end
          // Saturating: a request handshake on the timeout cycle wins, and the
          // timeout then fires on the next WAIT_RSP cycle.
          if (!tmo_hit) begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        WAIT_RSP: begin
          // A response handshake beats a timeout landing on the same edge.
          if (rsp_valid_i) begin
            rsp_q <= rsp_data_i;
            ack_q <= 1'b1;
            state <= ACK_HIGH;
          end
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_q     <= ERR_RSP;
            ack_q     <= 1'b1;
            state     <= ACK_HIGH;
            timeout_q <= 1'b1;
          end
          if (!tmo_hit) begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        ACK_HIGH: begin
          // Return to IDLE only; a fresh request edge is seen from IDLE on a
          // later cycle, guaranteeing an idle gap between transactions.
          if (!req_synced) begin
            ack_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Local handshake outputs decode the state register only.
  assign req_valid_o      = (state == REQ_VALID);
  assign rsp_ready_o      = (state == WAIT_RSP);
  assign busy_o           = (state != IDLE);
  assign req_data_o       = req_q;
  assign async_ack_o      = ack_q;
  assign async_rsp_data_o = rsp_q;

endmodule

// File: tb/tb_cdc_4phase_rsp.sv
// tb_cdc_4phase_rsp: directed self-checking bench for cdc_4phase_rsp.
// Latency: checks exact edge counts for request valid and acknowledge.
// Backpressure: exercises stalled req_ready_i and rsp_valid_i.
module tb_cdc_4phase_rsp;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        async_req_i;
  logic [31:0] async_req_data_i;
  logic        async_ack_o;
  logic [31:0] async_rsp_data_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_data_o;
  logic        rsp_valid_i;
  logic        rsp_ready_o;
  logic [31:0] rsp_data_i;
  logic        busy_o;
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
  logic        timeout_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cdc_4phase_rsp #(
    .SYNC_STAGES     (2)
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
   ,.TIMEOUT_CYCLES  (8)
`endif
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .async_req_i      (async_req_i),
    .async_req_data_i (async_req_data_i),
    .async_ack_o      (async_ack_o),
    .async_rsp_data_o (async_rsp_data_o),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .req_data_o       (req_data_o),
    .rsp_valid_i      (rsp_valid_i),
    .rsp_ready_o      (rsp_ready_o),
    .rsp_data_i       (rsp_data_i),
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
    .timeout_o        (timeout_o),
`endif
    .busy_o           (busy_o)
  );

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drop the request and wait for the acknowledge to fall.
  task automatic close_txn(input string name);
    async_req_i = 1'b0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    for (int n = 0; n < 20 && async_ack_o; n++) step();
    checks++;
    if (async_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack_release: ack=%b expected 0", name, async_ack_o);
    end
  endtask

  task automatic test_reset();
    rst_ni           = 1'b0;
    async_req_i      = 1'b0;
    async_req_data_i = 32'hDEAD_0000;
    req_ready_i      = 1'b0;
    rsp_valid_i      = 1'b0;
    rsp_data_i       = 32'h0;
    step();
    step();
    checks++;
    if ({async_ack_o, req_valid_o, rsp_ready_o, busy_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ack/rv/rr/busy=%b expected 0000",
               {async_ack_o, req_valid_o, rsp_ready_o, busy_o});
    end
    checks++;
    if (async_rsp_data_o !== 32'h0 || req_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rsp=%h req=%h expected 0/0", async_rsp_data_o, req_data_o);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single();
    async_req_data_i = 32'hA5A5_0001;
    req_ready_i      = 1'b1;
    rsp_valid_i      = 1'b1;
    rsp_data_i       = 32'h0000_BEEF;
    async_req_i      = 1'b1;            // raised just after edge 0
    step();                             // edge 1
    step();                             // edge 2
    checks++;
    if (req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_early: req_valid=%b expected 0 at edge 2", req_valid_o);
    end
    step();                             // edge 3
    checks++;
    if (req_valid_o !== 1'b1 || req_data_o !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_valid_edge3: valid=%b data=%h expected 1/a5a50001", req_valid_o, req_data_o);
    end
    step();                             // edge 4
    checks++;
    if (rsp_ready_o !== 1'b1 || async_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL single_wait_rsp: rsp_ready=%b ack=%b expected 1/0", rsp_ready_o, async_ack_o);
    end
    step();                             // edge 5
    checks++;
    if (async_ack_o !== 1'b1 || async_rsp_data_o !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL single_ack_edge5: ack=%b rsp=%h expected 1/0000beef", async_ack_o, async_rsp_data_o);
    end
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    async_req_i = 1'b0;
    step();
    step();
    checks++;
    if (async_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL single_ack_hold: ack=%b expected 1 two edges after drop", async_ack_o);
    end
    step();
    checks++;
    if (async_ack_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_fall: ack=%b busy=%b expected 0/0 three edges after drop", async_ack_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    async_req_data_i = 32'h1234_5678;
    req_ready_i      = 1'b0;
    rsp_valid_i      = 1'b0;
    rsp_data_i       = 32'h0000_0777;
    async_req_i      = 1'b1;
    for (int n = 0; n < 20 && !req_valid_o; n++) step();
    checks++;
    if (req_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_seen: req_valid=%b expected 1", req_valid_o);
    end
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (req_valid_o !== 1'b1 || req_data_o !== 32'h1234_5678 ||
          async_ack_o !== 1'b0 || busy_o !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_req_stall: %0d bad cycles expected 0", bad);
    end
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    bad = 0;
    for (int n = 0; n < 7; n++) begin
      if (rsp_ready_o !== 1'b1 || async_ack_o !== 1'b0 || busy_o !== 1'b1 || req_valid_o !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_rsp_stall: %0d bad cycles expected 0", bad);
    end
    rsp_valid_i = 1'b1;
    step();
    checks++;
    if (async_ack_o !== 1'b1 || async_rsp_data_o !== 32'h0000_0777) begin
      errors++;
      $display("FAIL bp_ack: ack=%b rsp=%h expected 1/00000777", async_ack_o, async_rsp_data_o);
    end
    close_txn("bp");
  endtask

  task automatic test_data_stability();
    async_req_data_i = 32'hCAFE_0042;
    req_ready_i      = 1'b0;
    rsp_valid_i      = 1'b0;
    rsp_data_i       = 32'h0000_0042;
    async_req_i      = 1'b1;
    for (int n = 0; n < 20 && !req_valid_o; n++) step();
    async_req_data_i = 32'h0BAD_0BAD;
    step();
    step();
    checks++;
    if (req_valid_o !== 1'b1 || req_data_o !== 32'hCAFE_0042) begin
      errors++;
      $display("FAIL stab_req_data: valid=%b data=%h expected 1/cafe0042", req_valid_o, req_data_o);
    end
    req_ready_i = 1'b1;
    rsp_valid_i = 1'b1;
    for (int n = 0; n < 20 && !async_ack_o; n++) step();
    close_txn("stab");
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [4];
    int          idle_seen;
    idle_seen   = 0;
    req_ready_i = 1'b1;
    rsp_valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      async_req_data_i = 32'(i);
      rsp_data_i       = 32'(i) + 32'h100;
      async_req_i      = 1'b1;
      for (int n = 0; n < 30 && !async_ack_o; n++) step();
      got[i-1] = async_rsp_data_o;
      async_req_i = 1'b0;
      for (int n = 0; n < 30 && async_ack_o; n++) step();
      if (busy_o === 1'b0) idle_seen++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== 32'h101 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_rsp%0d: got %h expected %h", i, got[i], 32'h101 + 32'(i));
      end
    end
    checks++;
    if (idle_seen !== 4) begin
      errors++;
      $display("FAIL b2b_idle_gap: idle seen %0d of 4 expected 4", idle_seen);
    end
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    async_req_data_i = 32'h0000_5EED;
    req_ready_i      = 1'b1;
    rsp_valid_i      = 1'b0;
    rsp_data_i       = 32'h0000_AAAA;
    async_req_i      = 1'b1;
    for (int n = 0; n < 20 && !rsp_ready_o; n++) step();
    checks++;
    if (rsp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_reach_wait: rsp_ready=%b expected 1", rsp_ready_o);
    end
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    checks++;
    if (async_ack_o !== 1'b0 || req_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: ack=%b valid=%b busy=%b expected 0/0/0", async_ack_o, req_valid_o, busy_o);
    end
    step();
    step();
    checks++;
    if (req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_early: req_valid=%b expected 0 two edges after release", req_valid_o);
    end
    step();
    checks++;
    if (req_valid_o !== 1'b1 || req_data_o !== 32'h0000_5EED) begin
      errors++;
      $display("FAIL rst_mid_reserve: valid=%b data=%h expected 1/00005eed", req_valid_o, req_data_o);
    end
    rsp_valid_i = 1'b1;
    for (int n = 0; n < 20 && !async_ack_o; n++) step();
    checks++;
    if (async_ack_o !== 1'b1 || async_rsp_data_o !== 32'h0000_AAAA) begin
      errors++;
      $display("FAIL rst_mid_ack: ack=%b rsp=%h expected 1/0000aaaa", async_ack_o, async_rsp_data_o);
    end
    close_txn("rst_mid");
  endtask

`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
  task automatic test_timeout();
    async_req_data_i = 32'h0000_7007;
    req_ready_i      = 1'b0;
    rsp_valid_i      = 1'b0;
    async_req_i      = 1'b1;
    for (int n = 0; n < 20 && !req_valid_o; n++) step();   // entered REQ_VALID at edge E
    for (int n = 0; n < 7; n++) step();                    // edge E+7
    checks++;
    if (async_ack_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: ack=%b timeout=%b expected 0/0", async_ack_o, timeout_o);
    end
    step();                                                // edge E+8
    checks++;
    if (async_ack_o !== 1'b1 || async_rsp_data_o !== 32'hFFFF_FFFF || timeout_o !== 1'b1 ||
        req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire: ack=%b rsp=%h timeout=%b valid=%b expected 1/ffffffff/1/0",
               async_ack_o, async_rsp_data_o, timeout_o, req_valid_o);
    end
    req_ready_i = 1'b1;
    step();
    checks++;
    if (timeout_o !== 1'b0 || req_valid_o !== 1'b0 || rsp_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: timeout=%b valid=%b rsp_ready=%b expected 0/0/0", timeout_o, req_valid_o, rsp_ready_o);
    end
    close_txn("tmo");
    // Response handshake on the same edge as the timeout.
    async_req_data_i = 32'h0000_7008;
    rsp_data_i       = 32'h0000_1234;
    req_ready_i      = 1'b1;
    rsp_valid_i      = 1'b0;
    async_req_i      = 1'b1;
    for (int n = 0; n < 20 && !req_valid_o; n++) step();   // edge E
    for (int n = 0; n < 7; n++) step();                    // edge E+7, in WAIT_RSP
    rsp_valid_i = 1'b1;
    step();                                                // edge E+8
    checks++;
    if (async_ack_o !== 1'b1 || async_rsp_data_o !== 32'h0000_1234 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_race: ack=%b rsp=%h timeout=%b expected 1/00001234/0",
               async_ack_o, async_rsp_data_o, timeout_o);
    end
    rsp_valid_i = 1'b0;
    step();
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_race_quiet: timeout=%b expected 0", timeout_o);
    end
    close_txn("tmo_race");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_data_stability();
    test_back_to_back();
    test_reset_mid();
`ifdef CDC_4PHASE_RSP_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
